// File: rtl/writeback_stage_pkg.sv
// Shared encodings for the writeback stage: result-source select, load funct3 values
// and FSM states.
package writeback_stage_pkg;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_ALU  = 2'b01,
        WB_MEM  = 2'b10,
        WB_PC4  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/writeback_stage_load.sv
// Combinational load extraction: picks the byte or halfword lane out of the aligned
// word, then sign/zero-extends it; flags misaligned or unknown load types.
module load_extend
    import writeback_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] rdata,
    output logic [XLEN-1:0] data_o,
    output logic            misalign_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{addr_lo, 3'b000} +: 8];
    assign half_sel = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        data_o     = '0;
        misalign_o = 1'b0;
        case (funct3)
            F3_LB:  data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH: begin
                data_o     = {{(XLEN-16){half_sel[15]}}, half_sel};
                misalign_o = addr_lo[0];
            end
            F3_LHU: begin
                data_o     = {{(XLEN-16){1'b0}}, half_sel};
                misalign_o = addr_lo[0];
            end
            F3_LW: begin
                data_o     = rdata;
                misalign_o = (addr_lo != 2'b00);
            end
            default: misalign_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: accepts retiring instructions, selects the result source, waits for
// load data when needed and drives a registered register-file write port.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic [1:0]            in_wb_sel,
    input  logic [XLEN-1:0]       in_alu_result,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [2:0]            in_funct3,
    input  logic [1:0]            in_addr_lo,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  wen,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [XLEN-1:0]       wdata,
    output logic                  misalign_err,
    output logic [CNT_W-1:0]      retire_count
);

    wb_state_e             state_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [2:0]            funct3_q;
    logic [1:0]            addr_lo_q;
    logic                  wen_q;
    logic [REG_ADDR_W-1:0] waddr_q;
    logic [XLEN-1:0]       wdata_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    logic                  accept;
    logic [XLEN-1:0]       wdata_d;
    logic [XLEN-1:0]       ld_data;
    logic                  ld_misalign;

    // Ready is gated by rst so nothing can be accepted in the reset cycle itself.
    assign in_ready = !rst && (state_q == ST_IDLE);
    assign accept   = in_valid && in_ready;

    assign wdata_d = (in_wb_sel == WB_PC4) ? in_pc + XLEN'(4) : in_alu_result;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .funct3     (funct3_q),
        .addr_lo    (addr_lo_q),
        .rdata      (mem_rdata),
        .data_o     (ld_data),
        .misalign_o (ld_misalign)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rd_q      <= '0;
            funct3_q  <= '0;
            addr_lo_q <= '0;
            wen_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wen_q <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rd_q      <= in_rd;
                        funct3_q  <= in_funct3;
                        addr_lo_q <= in_addr_lo;
                        if (in_wb_sel == WB_MEM) begin
                            state_q <= ST_WAIT_MEM;
                        end else begin
                            waddr_q <= in_rd;
                            wdata_q <= wdata_d;
                            wen_q   <= (in_wb_sel != WB_NONE) && (in_rd != '0);
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        state_q <= ST_IDLE;
                        waddr_q <= rd_q;
                        wdata_q <= ld_data;
                        wen_q   <= !ld_misalign && (rd_q != '0);
                        err_q   <= ld_misalign;
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wen          = wen_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign misalign_err = err_q;
    assign retire_count = cnt_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage: the driver pushes expected writebacks,
// a monitor pops and compares whenever the stage writes, flags an error or retires.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = '0;
    logic [1:0]  in_wb_sel = '0;
    logic [31:0] in_alu_result = '0;
    logic [31:0] in_pc = '0;
    logic [2:0]  in_funct3 = '0;
    logic [1:0]  in_addr_lo = '0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        wen;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        misalign_err;
    logic [31:0] retire_count;

    always #5 clk = ~clk;

    writeback_stage #(.XLEN(32), .REG_ADDR_W(5), .CNT_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_alu_result (in_alu_result),
        .in_pc         (in_pc),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .mem_rvalid    (mem_rvalid),
        .mem_rdata     (mem_rdata),
        .wen           (wen),
        .waddr         (waddr),
        .wdata         (wdata),
        .misalign_err  (misalign_err),
        .retire_count  (retire_count)
    );

    typedef struct {
        logic        wen;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          failures = 0;
    logic        mon_en = 1'b0;
    logic        rst_at_edge = 1'b0;
    int unsigned retired = 0;
    logic [4:0]  p_rd;
    logic [2:0]  p_f3;
    logic [1:0]  p_alo;

    always @(posedge clk) rst_at_edge <= rst;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference load semantics expressed as shifts, masks and two's-complement offsets.
    function automatic exp_t load_model(input logic [4:0] rd, input logic [2:0] f3,
                                        input logic [1:0] alo, input logic [31:0] rdata);
        exp_t        e;
        int unsigned b;
        int unsigned h;
        logic [31:0] v;
        logic        err;
        b   = (rdata >> (8 * alo)) & 32'hFF;
        h   = (rdata >> (16 * (alo / 2))) & 32'hFFFF;
        v   = 32'h0;
        err = 1'b0;
        case (f3)
            3'd0: v = (b > 127) ? b + 32'hFFFF_FF00 : b;
            3'd4: v = b;
            3'd1: begin v = (h > 32767) ? h + 32'hFFFF_0000 : h; err = (alo % 2) != 0; end
            3'd5: begin v = h; err = (alo % 2) != 0; end
            3'd2: begin v = rdata; err = (alo != 0); end
            default: err = 1'b1;
        endcase
        e.wen   = !err && (rd != 0);
        e.waddr = rd;
        e.wdata = v;
        e.err   = err;
        e.chk   = !err;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] rd, input logic [1:0] sel, input logic [31:0] alu,
                        input logic [31:0] pc, input logic [2:0] f3, input logic [1:0] alo,
                        input logic spur);
        exp_t e;
        in_valid      = 1'b1;
        in_rd         = rd;
        in_wb_sel     = sel;
        in_alu_result = alu;
        in_pc         = pc;
        in_funct3     = f3;
        in_addr_lo    = alo;
        mem_rvalid    = spur;
        mem_rdata     = $urandom;
        #1 check("in_ready_idle", in_ready, 1);
        if (sel == 2'b10) begin
            p_rd  = rd;
            p_f3  = f3;
            p_alo = alo;
        end else begin
            e.wen   = (sel != 2'b00) && (rd != 0);
            e.waddr = rd;
            e.wdata = (sel == 2'b11) ? pc + 32'd4 : alu;
            e.err   = 1'b0;
            e.chk   = (sel != 2'b00);
            q.push_back(e);
            retired++;
        end
        step();
        in_valid   = 1'b0;
        mem_rvalid = 1'b0;
    endtask

    task automatic ret(input logic [31:0] rdata, input int delay);
        for (int i = 0; i < delay; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            #1 check("in_ready_wait", in_ready, 0);
            step();
        end
        in_valid   = 1'($urandom_range(0, 1));
        mem_rvalid = 1'b1;
        mem_rdata  = rdata;
        #1 check("in_ready_rvalid", in_ready, 0);
        q.push_back(load_model(p_rd, p_f3, p_alo, rdata));
        retired++;
        step();
        mem_rvalid = 1'b0;
        in_valid   = 1'b0;
    endtask

    initial begin : monitor
        exp_t        e;
        logic [31:0] exp_cnt;
        exp_cnt = '0;
        wait (mon_en);
        forever begin
            @(negedge clk);
            if (rst_at_edge) begin
                check("rst_wen", wen, 0);
                check("rst_err", misalign_err, 0);
                check("rst_count", retire_count, 0);
                check("rst_waddr", waddr, 0);
                check("rst_wdata", wdata, 0);
                check("q_empty_at_rst", q.size(), 0);
                q.delete();
                exp_cnt = '0;
            end else if (wen === 1'b1 || misalign_err === 1'b1 || retire_count !== exp_cnt) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: wen=%0b err=%0b count=%0d expected no activity",
                             wen, misalign_err, retire_count);
                    exp_cnt = retire_count;
                end else begin
                    e = q.pop_front();
                    exp_cnt = exp_cnt + 1;
                    check("retire_count", retire_count, exp_cnt);
                    check("wen", wen, e.wen);
                    check("misalign_err", misalign_err, e.err);
                    if (e.chk) begin
                        check("waddr", waddr, e.waddr);
                        check("wdata", wdata, e.wdata);
                    end
                end
            end
        end
    end

    initial begin : driver
        logic [2:0] f3_tab [8];
        logic [1:0] sel;
        f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd2};
        @(negedge clk);
        mon_en = 1'b1;
        #1 check("in_ready_in_rst", in_ready, 0);
        step();
        rst = 1'b0;
        #1 check("in_ready_after_rst", in_ready, 1);

        send(5'd5, 2'b01, 32'h0000_1234, 32'h0, 3'd0, 2'd0, 1'b0);
        send(5'd1, 2'b11, 32'h0, 32'hFFFF_FFFC, 3'd0, 2'd0, 1'b0);
        send(5'd9, 2'b10, 32'h0, 32'h0, 3'd0, 2'd2, 1'b0);
        ret(32'h0080_0000, 2);
        send(5'd9, 2'b10, 32'h0, 32'h0, 3'd4, 2'd2, 1'b0);
        ret(32'h0080_0000, 2);
        send(5'd10, 2'b10, 32'h0, 32'h0, 3'd1, 2'd2, 1'b0);
        ret(32'h8001_0000, 1);
        send(5'd0, 2'b01, 32'hDEAD_BEEF, 32'h0, 3'd0, 2'd0, 1'b0);
        send(5'd3, 2'b10, 32'h0, 32'h0, 3'd2, 2'd1, 1'b0);
        ret(32'h1234_5678, 0);
        send(5'd4, 2'b00, 32'h5555_0000, 32'h0, 3'd0, 2'd0, 1'b0);

        // Abort a pending load with reset coinciding with the data return.
        send(5'd7, 2'b10, 32'h0, 32'h0, 3'd2, 2'd0, 1'b0);
        rst        = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_F00D;
        step();
        rst        = 1'b0;
        mem_rvalid = 1'b0;
        retired    = 0;
        #1 check("in_ready_post_abort", in_ready, 1);

        send(5'd11, 2'b01, 32'h0000_0011, 32'h0, 3'd0, 2'd0, 1'b0);
        send(5'd12, 2'b01, 32'h0000_0022, 32'h0, 3'd0, 2'd0, 1'b1);
        send(5'd13, 2'b01, 32'h0000_0033, 32'h0, 3'd0, 2'd0, 1'b0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                in_valid   = 1'b0;
                mem_rvalid = 1'($urandom_range(0, 1));
                mem_rdata  = $urandom;
                #1 check("in_ready_idle_gap", in_ready, 1);
                step();
                mem_rvalid = 1'b0;
            end else begin
                sel = 2'($urandom_range(0, 3));
                send(($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom), sel, $urandom, $urandom,
                     f3_tab[$urandom_range(0, 7)], 2'($urandom), 1'($urandom_range(0, 1)));
                if (sel == 2'b10) ret($urandom, $urandom_range(0, 3));
            end
        end

        repeat (3) step();
        #1;
        check("q_drained", q.size(), 0);
        check("final_retire_count", retire_count, retired);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
